// File: rtl/freq_meter_pkg.sv
// Shared types and defaults for the gated frequency meter.
package freq_meter_pkg;

   typedef enum logic {IDLE = 1'b0, GATE = 1'b1} fm_state_t;

   localparam int CLK_HZ          = 50_000_000;
   localparam int DEF_GATE_CYCLES = CLK_HZ;     // 1 s window => count in Hz
   localparam int DEF_CNT_W       = 26;
   localparam int DEF_SYNC_STAGES = 2;

   // Window timer width; a 1-cycle window still needs a 1-bit timer.
   function automatic int timer_w(input int cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/freq_meter_if.sv
// Measurement control / result handshake bundle between meter and consumer.
interface freq_meter_if import freq_meter_pkg::*; #(
   parameter int CNT_W = DEF_CNT_W
);
   logic             enable;
   logic             sig_in;
   logic             ack;
   logic [CNT_W-1:0] count;
   logic             valid;
   logic             overflow;
   logic             overrun;

   // master: consumer / stimulus side
   modport master (output enable, sig_in, ack,
                   input  count, valid, overflow, overrun);
   // slave: the meter itself
   modport slave  (input  enable, sig_in, ack,
                   output count, valid, overflow, overrun);
endinterface

// File: rtl/freq_meter_sync_edge_detect.sv
// Synchroniser for an asynchronous input followed by a registered
// rising-edge detector. A rise sampled on edge k gives a one-cycle pulse
// visible after edge k+SYNC_STAGES.
module sync_edge_detect import freq_meter_pkg::*; #(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic sig_in,
   output logic pulse
);
   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;

   // synchroniser chain, edge history and registered pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         sync  <= '0;
         prev  <= 1'b0;
         pulse <= 1'b0;
      end else begin
         sync  <= {sync[SYNC_STAGES-2:0], sig_in};
         prev  <= sync[SYNC_STAGES-1];
         pulse <= sync[SYNC_STAGES-1] & ~prev;
      end
   end
endmodule

// File: rtl/freq_meter.sv
// Gated frequency counter: counts input rises over GATE_CYCLES clocks with
// back-to-back windows, then publishes the count with a Valid/Ack handshake.
module freq_meter import freq_meter_pkg::*; #(
   parameter int GATE_CYCLES = DEF_GATE_CYCLES,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic         clk,
   input  logic         rst,
   freq_meter_if.slave  bus
);
   localparam int               TMR_W   = timer_w(GATE_CYCLES);
   localparam logic [TMR_W-1:0] LAST    = TMR_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   fm_state_t        state, state_nxt;
   logic [TMR_W-1:0] timer, timer_nxt, cur_t;
   logic [CNT_W-1:0] edges, edges_nxt, win_cnt;
   logic             sat, sat_nxt, win_sat;
   logic             win_end;
   logic             pulse;

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .rst    (rst),
      .sig_in (bus.sig_in),
      .pulse  (pulse)
   );

   // state, timer and edge counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         timer <= '0;
         edges <= '0;
         sat   <= 1'b0;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
         edges <= edges_nxt;
         sat   <= sat_nxt;
      end
   end

   // next state, window timing and saturating edge accumulation
   always_comb begin
      state_nxt = bus.enable ? GATE : IDLE;
      timer_nxt = '0;
      edges_nxt = '0;
      sat_nxt   = 1'b0;
      win_end   = 1'b0;
      // the first enabled cycle after idle is always window cycle 0
      cur_t     = (state == IDLE) ? '0 : timer;
      // this cycle's pulse is included, so a last-cycle edge joins its window
      win_cnt   = edges;
      win_sat   = sat;
      if (pulse) begin
         if (edges == CNT_MAX) win_sat = 1'b1;
         else                  win_cnt = edges + 1'b1;
      end
      if (bus.enable) begin
         if (cur_t == LAST) begin
            win_end = 1'b1;            // counter restarts at 0 for the new window
         end else begin
            timer_nxt = cur_t + 1'b1;
            edges_nxt = win_cnt;
            sat_nxt   = win_sat;
         end
      end
   end

   // result publication and Valid/Ack handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.count    <= '0;
         bus.valid    <= 1'b0;
         bus.overflow <= 1'b0;
         bus.overrun  <= 1'b0;
      end else if (win_end) begin
         bus.count    <= win_cnt;
         bus.overflow <= win_sat;
         bus.valid    <= 1'b1;
         // unacknowledged result being replaced; a same-cycle ack clears it
         bus.overrun  <= bus.valid & ~bus.ack;
      end else if (bus.valid && bus.ack) begin
         bus.valid    <= 1'b0;
         bus.overrun  <= 1'b0;
      end
   end
endmodule
